// File: rtl/fifo_rd_drain_if.sv
// FIFO read port plus downstream valid/ready stream of the read-side drain.
// master = drain block, slave = FIFO/downstream side.
interface fifo_rd_drain_if #(
  parameter int DWIDTH = 8
);
  logic              pop;
  logic              empty;
  logic [DWIDTH-1:0] rdata;
  logic              out_valid;
  logic [DWIDTH-1:0] out_data;
  logic              out_ready;

  modport master (
    output pop, out_valid, out_data,
    input  empty, rdata, out_ready
  );

  modport slave (
    input  pop, out_valid, out_data,
    output empty, rdata, out_ready
  );
endinterface

// File: rtl/fifo_rd_drain.sv
// Async-FIFO read-side drain: pops into a 2-entry output buffer (1-cycle latency,
// out_ready never reaches pop) with flush-discard mode; RD_WORD_CNT_EN adds word_cnt.
module fifo_rd_drain #(
  parameter int DWIDTH   = 8
`ifdef RD_WORD_CNT_EN
  , parameter int CNTWIDTH = 16
`endif
) (
  input  logic                rclk,
  input  logic                reset,
  input  logic                en,
  input  logic                flush,
  fifo_rd_drain_if.master     bus,
  output logic                busy,
  output logic                flush_done
`ifdef RD_WORD_CNT_EN
  , output logic [CNTWIDTH-1:0] word_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [DWIDTH-1:0] ent0_q, ent0_d;
  logic [DWIDTH-1:0] ent1_q, ent1_d;
  logic              flush_done_q, flush_done_d;
  logic              pop_c;
  logic              enq;
  logic              deq;

  // Pop depends only on registered occupancy, so downstream ready is off this path.
  always_comb begin
    pop_c = 1'b0;
    case (state_q)
      RUN:     pop_c = !bus.empty && (cnt_q < 2'd2);
      FLUSH:   pop_c = !bus.empty;
      default: pop_c = 1'b0;
    endcase
  end

  assign enq = (state_q == RUN) && pop_c;
  assign deq = (cnt_q != 2'd0) && bus.out_ready;

  always_comb begin
    state_d      = state_q;
    flush_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush)   state_d = FLUSH;
        else if (en) state_d = RUN;
      end
      RUN: begin
        if (flush)    state_d = FLUSH;
        else if (!en) state_d = IDLE;
      end
      FLUSH: begin
        if (bus.empty) begin
          state_d      = IDLE;
          flush_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    if ((state_d == FLUSH) && (state_q != FLUSH)) begin
      cnt_d  = 2'd0;
      ent0_d = '0;
      ent1_d = '0;
    end else begin
      case ({enq, deq})
        2'b10: begin
          if (cnt_q == 2'd0) ent0_d = bus.rdata;
          else               ent1_d = bus.rdata;
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          ent0_d = (cnt_q == 2'd2) ? ent1_q : '0;
          ent1_d = '0;
          cnt_d  = cnt_q - 2'd1;
        end
        // Only reachable with cnt == 1: the new word replaces the departing head.
        2'b11:   ent0_d = bus.rdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge rclk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 2'd0;
      ent0_q       <= '0;
      ent1_q       <= '0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ent0_q       <= ent0_d;
      ent1_q       <= ent1_d;
      flush_done_q <= flush_done_d;
    end
  end

  assign bus.pop       = pop_c;
  assign bus.out_valid = (cnt_q != 2'd0);
  assign bus.out_data  = ent0_q;
  assign busy          = (state_q != IDLE) || (cnt_q != 2'd0);
  assign flush_done    = flush_done_q;

`ifdef RD_WORD_CNT_EN
  logic [CNTWIDTH-1:0] word_cnt_q, word_cnt_d;

  always_comb begin
    word_cnt_d = word_cnt_q;
    if (deq) word_cnt_d = word_cnt_q + CNTWIDTH'(1);
  end

  always_ff @(posedge rclk or posedge reset) begin
    if (reset) word_cnt_q <= '0;
    else       word_cnt_q <= word_cnt_d;
  end

  assign word_cnt = word_cnt_q;
`endif

endmodule
